// File: rtl/adder_8bit_pkg.sv
// -----------------------------------------------------------------------------
// adder_8bit_pkg
// Purpose : Shared constants for the registered ripple-carry adder.
// Contents: ADDER_WIDTH - default operand/sum width (8 is the verified size).
// -----------------------------------------------------------------------------
package adder_8bit_pkg;

    localparam int ADDER_WIDTH = 8;

endpackage : adder_8bit_pkg

// File: rtl/adder_8bit_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Purpose : One-bit full-adder cell, the building block of the ripple chain.
// Ports   : a, b - operand bits
//           ci   - carry in from the next-lower bit
//           s    - sum bit
//           co   - carry out to the next-higher bit
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    // Propagate term is shared between the sum and the carry.
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule : full_adder

// File: rtl/adder_8bit.sv
// -----------------------------------------------------------------------------
// adder_8bit
// Purpose : Unsigned WIDTH-bit adder with carry-in/carry-out. A ripple chain
//           of full_adder cells computes a + b + cin; the result is
//           registered once so downstream logic sees a glitch-free value
//           exactly one cycle after the operands are sampled.
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous active-low reset, clears sum/cout
//           a, b  - unsigned operands, WIDTH bits
//           cin   - carry into bit 0
//           sum   - registered (a + b + cin) mod 2**WIDTH
//           cout  - registered carry out of bit WIDTH-1
// -----------------------------------------------------------------------------
module adder_8bit
    import adder_8bit_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // c[i] is the carry into bit i; c[WIDTH] is the final carry out.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum_d[i]),
            .co (c[i+1])
        );
    end

    assign cout_d = c[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : adder_8bit

// File: tb/tb_adder_8bit.sv
// -----------------------------------------------------------------------------
// tb_adder_8bit
// Directed and random self-check of adder_8bit. Expected values are written
// as {cout, sum} 9-bit constants or computed as a 9-bit a + b + cin.
// -----------------------------------------------------------------------------
module tb_adder_8bit;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;

    int checks   = 0;
    int failures = 0;

    adder_8bit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] exp);
        logic [8:0] got;
        got = {cout, sum};
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s: got cout=%b sum=0x%h, expected cout=%b sum=0x%h",
                   tag, got[8], got[7:0], exp[8], exp[7:0]);
        end
    endtask

    // Advance past the next rising edge, sampling 1 ns later.
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] model;

        // Reset held low with non-zero inputs while the clock runs.
        rst_n = 1'b1;
        a = 8'hAA; b = 8'h55; cin = 1'b1;
        #2 rst_n = 1'b0;
        #1 check("reset_async", 9'h000);
        for (int i = 0; i < 3; i++) begin
            edge_step();
            check("reset_hold", 9'h000);
        end

        // Basic: release and add 1 + 2 + 1.
        rst_n = 1'b1;
        a = 8'h01; b = 8'h02; cin = 1'b1;
        edge_step();
        check("basic", 9'h004);
        #100 check("basic_hold", 9'h004);

        // Carry wrap.
        a = 8'hFF; b = 8'h01; cin = 1'b0;
        edge_step();
        check("wrap", 9'h100);

        // Maximum.
        a = 8'hFF; b = 8'hFF; cin = 1'b1;
        edge_step();
        check("max", 9'h1FF);

        // All zero.
        a = 8'h00; b = 8'h00; cin = 1'b0;
        edge_step();
        check("zero", 9'h000);

        // Back-to-back vectors on consecutive edges.
        a = 8'h10; b = 8'h20; cin = 1'b0;
        edge_step();
        check("pipe_0", 9'h030);
        a = 8'h7F; b = 8'h01; cin = 1'b1;
        edge_step();
        check("pipe_1", 9'h081);

        // Asynchronous reset between edges discards the held result.
        #2 rst_n = 1'b0;
        #1 check("mid_reset", 9'h000);
        a = 8'h12; b = 8'h34; cin = 1'b1;
        edge_step();
        check("mid_reset_edge", 9'h000);
        rst_n = 1'b1;
        edge_step();
        check("after_release", 9'h047);

        // Randomized vectors; each result is checked one edge after its inputs.
        for (int i = 0; i < 1000; i++) begin
            a   = 8'($urandom_range(0, 255));
            b   = 8'($urandom_range(0, 255));
            cin = 1'($urandom_range(0, 1));
            model = {1'b0, a} + {1'b0, b} + {8'b0, cin};
            edge_step();
            check("random", model);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_adder_8bit
